// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: one command byte out over open-drain clock/data pull-low enables.
// Latency: INHIBIT_CYCLES of clock inhibit, then 11 device clock falling edges, then bus-idle wait.
// Backpressure: o_tx_ready only in IDLE; i_tx_valid while busy is ignored (no queue).
//
// Ports:
//   i_clk, i_rst_n               system clock, asynchronous active-low reset
//   i_tx_data/i_tx_valid/o_tx_ready  command byte handshake (accept = valid && ready)
//   o_busy                       high in every state except IDLE (receive path must ignore the bus)
//   o_done / o_error             1-cycle pulses: byte ACKed / transfer aborted
//   o_err_code                   01 timeout, 10 NACK; held until the next accepted request
//   i_sclk, i_data               PS/2 lines (asynchronous, synchronised here)
//   o_sclk_oe, o_data_oe         1 = pull the corresponding line low
// Optional build macro: PS2_TX_RETRY_EN (resend the latched byte once after a NACK or timeout).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [1:0] o_err_code,
    input  logic       i_sclk,
    input  logic       i_data,
    output logic       o_sclk_oe,
    output logic       o_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Each post-REQ state is named for what its exiting falling edge puts on the wire,
    // so REQ..ACK consume exactly 11 device clock falling edges.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_PARITY    = 3'd4;
    localparam logic [2:0] S_STOP      = 3'd5;
    localparam logic [2:0] S_ACK       = 3'd6;
    localparam logic [2:0] S_WAIT_IDLE = 3'd7;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    logic [2:0]       sclk_sync_q, sclk_sync_d;   // [1] = synced, [2] = previous synced
    logic [1:0]       data_sync_q, data_sync_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;               // inhibit timer, then edge-to-edge timeout
    logic [8:0]       tx_q, tx_d;                 // {parity, byte} latched at accept
    logic [8:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             sclk_oe_q, sclk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
    logic             retry_q, retry_d;
`endif

    logic             sclk_s, data_s, sclk_fall;
    logic             fail;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] cnt_inc;

    assign sclk_s    = sclk_sync_q[1];
    assign data_s    = data_sync_q[1];
    assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], i_sclk};
        data_sync_d = {data_sync_q[0], i_data};
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_oe_d   = sclk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif

        // Edge-to-edge watchdog; a falling edge in the expiry cycle still wins.
        if (state_q != S_IDLE && state_q != S_INHIBIT) begin
            if (sclk_fall) begin
                cnt_d = '0;
            end else if (cnt_q == TMO_LAST) begin
                fail      = 1'b1;
                fail_code = ERR_TIMEOUT;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        case (state_q)
            S_IDLE: begin
                sclk_oe_d = 1'b0;
                data_oe_d = 1'b0;
                if (i_tx_valid) begin
                    tx_d       = {~^i_tx_data, i_tx_data};
                    err_code_d = ERR_NONE;
                    state_d    = S_INHIBIT;
                    cnt_d      = '0;
                    sclk_oe_d  = 1'b1;
                    data_oe_d  = (INHIBIT_CYCLES == 1);
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (!sclk_oe_q) begin
                    // Entered from a retry with both lines released; start holding the clock.
                    sclk_oe_d = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 1);
                end else if (cnt_q == INH_LAST) begin
                    state_d   = S_REQ;
                    sclk_oe_d = 1'b0;
                    cnt_d     = '0;
                    shift_d   = tx_q;
                end else begin
                    cnt_d = cnt_inc;
                    // Start bit goes low in the final inhibit cycle, while the clock is still held.
                    if (cnt_inc == INH_LAST) data_oe_d = 1'b1;
                end
            end
            S_REQ: begin
                if (sclk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                    bit_cnt_d = 3'd1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (sclk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (sclk_fall) begin
                    data_oe_d = ~shift_q[0];   // parity bit is all that is left in the shifter
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (sclk_fall) begin
                    data_oe_d = 1'b0;          // stop bit = released line
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                if (sclk_fall) begin
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (sclk_s && data_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                sclk_oe_d = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        if (fail) begin
            sclk_oe_d = 1'b0;
            data_oe_d = 1'b0;
            cnt_d     = '0;
            done_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = S_INHIBIT;
            end else begin
                state_d    = S_IDLE;
                error_d    = 1'b1;
                err_code_d = fail_code;
            end
`else
            state_d    = S_IDLE;
            error_d    = 1'b1;
            err_code_d = fail_code;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= 3'b111;
            data_sync_q <= 2'b11;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            sclk_oe_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_oe_q   <= sclk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) retry_q <= 1'b0;
        else          retry_q <= retry_d;
    end
`endif

    assign o_tx_ready = (state_q == S_IDLE);
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_error    = error_q;
    assign o_err_code = err_code_q;
    assign o_sclk_oe  = sclk_oe_q;
    assign o_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a PS/2 device model clocking at period 40.
// Latency: one accepted byte per table row, each run to completion before the next.
// Backpressure: requests only issued while the host reports ready, except the deliberate busy-valid case.
module tb_ps2_host_tx;

    localparam int INH     = 10;
    localparam int TMO     = 200;
    localparam int HALF    = 20;
    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_NOCLK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       o_tx_ready, o_busy, o_done, o_error, o_sclk_oe, o_data_oe;
    logic [1:0] o_err_code;
    logic       dev_sclk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    wire sclk_line = ~(o_sclk_oe | dev_sclk_low);
    wire data_line = ~(o_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_err_code (o_err_code),
        .i_sclk     (sclk_line),
        .i_data     (data_line),
        .o_sclk_oe  (o_sclk_oe),
        .o_data_oe  (o_data_oe)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, acc_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    typedef struct {
        logic [10:0] frame;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic        clocked;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic       done;
        logic       err;
        logic [1:0] code;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Wire image: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d, input logic ed, input logic ee,
                        input logic [1:0] ec, input logic clocked);
        exp_t e;
        e.frame   = frame_of(d);
        e.done    = ed;
        e.err     = ee;
        e.code    = ec;
        e.clocked = clocked;
        sb.push_back(e);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic dev_xfer(input int mode, output logic [10:0] frame,
                            output int inh_len, output int start_ovl);
        inh_len = 0;
        start_ovl = 0;
        frame = '0;
        for (int i = 0; i < 100; i++) begin
            if (o_sclk_oe) begin
                inh_len++;
                if (o_data_oe) start_ovl++;
            end else if (inh_len > 0) begin
                break;
            end
            @(negedge clk);
        end
        if (mode == M_NOCLK) return;
        repeat (5) @(negedge clk);
        frame[0] = data_line;
        for (int k = 0; k < 11; k++) begin
            dev_sclk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_sclk_low = 1'b0;
            if (k < 10) frame[k+1] = data_line;
            repeat (3) @(negedge clk);
            if (k == 9 && mode == M_ACK) dev_data_low = 1'b1;
            if (k == 10) dev_data_low = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic finish_txn(input string tag, input int mode, input logic [10:0] frame,
                              input int inh_len, input int start_ovl, input int d0, input int e0);
        exp_t e;
        check({tag, "_sb_has_entry"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_inhibit_len"}, inh_len, INH);
            check({tag, "_start_overlap"}, start_ovl, 1);
            if (e.clocked) check({tag, "_frame"}, frame, e.frame);
            check({tag, "_done_pulses"}, done_cnt - d0, e.done);
            check({tag, "_error_pulses"}, err_cnt - e0, e.err);
            check({tag, "_err_code"}, o_err_code, e.code);
            check({tag, "_oe_released"}, {o_sclk_oe, o_data_oe}, 2'b00);
            check({tag, "_ready"}, o_tx_ready, 1'b1);
            if (mode == M_NOCLK) check_range({tag, "_timeout_latency"}, err_cyc - acc_cyc, 205, 215);
        end
    endtask

    logic [10:0] fr;
    int il, so, d0, e0;
    logic ready_while_busy;
    int   sclk_seen;

    initial begin
        vecs[0] = '{8'hED, M_ACK,   1'b1, 1'b0, 2'b00};
        vecs[1] = '{8'h01, M_ACK,   1'b1, 1'b0, 2'b00};
        vecs[2] = '{8'hFF, M_NACK,  1'b0, 1'b1, 2'b10};
        vecs[3] = '{8'hF4, M_NOCLK, 1'b0, 1'b1, 2'b01};
        vecs[4] = '{8'h00, M_ACK,   1'b1, 1'b0, 2'b00};
        vecs[5] = '{8'h80, M_ACK,   1'b1, 1'b0, 2'b00};

        repeat (3) @(negedge clk);
        check("rst_ready", o_tx_ready, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_oe", {o_sclk_oe, o_data_oe}, 2'b00);
        check("rst_done_error", {o_done, o_error}, 2'b00);
        check("rst_err_code", o_err_code, 2'b00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send(vecs[v].data, vecs[v].done, vecs[v].err, vecs[v].code, vecs[v].mode != M_NOCLK);
            dev_xfer(vecs[v].mode, fr, il, so);
            wait_outcome(d0, e0);
            finish_txn($sformatf("vec%0d", v), vecs[v].mode, fr, il, so, d0, e0);
            repeat (20) @(negedge clk);
        end

        // Request while busy must be dropped: only 0xED appears, one completion.
        d0 = done_cnt;
        e0 = err_cnt;
        ready_while_busy = 1'b1;
        send(8'hED, 1'b1, 1'b0, 2'b00, 1'b1);
        fork
            dev_xfer(M_ACK, fr, il, so);
            begin
                repeat (100) @(negedge clk);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                ready_while_busy = o_tx_ready;
                repeat (50) @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        join
        wait_outcome(d0, e0);
        finish_txn("busy_valid", M_ACK, fr, il, so, d0, e0);
        check("busy_valid_ready_low", ready_while_busy, 1'b0);
        sclk_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_sclk_oe) sclk_seen++;
        end
        check("busy_valid_no_second_xfer", sclk_seen, 0);
        check("busy_valid_single_done", done_cnt - d0, 1);

        // Reset after the 4th data bit is on the wire.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h50, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (!o_sclk_oe) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            dev_sclk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_sclk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        check("rst_mid_bit3_driven_low", o_data_oe, 1'b1);
        check("rst_mid_busy_before", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_oe_immediate", {o_sclk_oe, o_data_oe}, 2'b00);
        check("rst_mid_busy_immediate", o_busy, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_mid_sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rst_mid_done_pulses", done_cnt - d0, e.done);
            check("rst_mid_error_pulses", err_cnt - e0, e.err);
            check("rst_mid_err_code", o_err_code, e.code);
        end
        check("rst_mid_ready_after", o_tx_ready, 1'b1);
        check("rst_mid_sclk_idle", o_sclk_oe, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
